// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcode constants, the ID/EX entry layout
// and the immediate generator used by the decode stage.
package decode_stage_pkg;

   localparam int XLEN_W = 32;
   localparam int REG_AW = 5;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   // One ID/EX pipeline entry.
   typedef struct packed {
      logic              valid;
      logic [XLEN_W-1:0] pc;
      logic [XLEN_W-1:0] rs1_val;
      logic [XLEN_W-1:0] rs2_val;
      logic [XLEN_W-1:0] imm;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic [6:0]        opcode;
      logic [2:0]        funct3;
      logic              funct7b5;
      logic              rd_we;
      logic              mem_re;
      logic              mem_we;
      logic              branch;
      logic              jump;
   } idex_t;

   localparam idex_t IDEX_ZERO = idex_t'({$bits(idex_t){1'b0}});

   // Sign-extended immediate selected by instruction format; unknown opcodes give 0.
   function automatic logic [31:0] imm_gen(input logic [31:0] ir);
      logic [31:0] imm;
      imm = 32'd0;
      case (ir[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR:
            imm = {{20{ir[31]}}, ir[31:20]};
         OPC_STORE:
            imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         OPC_BRANCH:
            imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm = {ir[31:12], 12'd0};
         OPC_JAL:
            imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         default:
            imm = 32'd0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of fetch-side, hazard, write-back and ID/EX signals around the decode stage.
interface decode_stage_if #(parameter int XLEN = 32);

   logic [XLEN-1:0] ir;
   logic [XLEN-1:0] npc;
   logic            flush;
   logic            ex_mem_re;
   logic [4:0]      ex_rd;
   logic            wb_we;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            stallF;
   logic            stallD;
   logic            e_valid;
   logic [XLEN-1:0] e_pc;
   logic [XLEN-1:0] e_rs1_val;
   logic [XLEN-1:0] e_rs2_val;
   logic [XLEN-1:0] e_imm;
   logic [4:0]      e_rs1;
   logic [4:0]      e_rs2;
   logic [4:0]      e_rd;
   logic [6:0]      e_opcode;
   logic [2:0]      e_funct3;
   logic            e_funct7b5;
   logic            e_rd_we;
   logic            e_mem_re;
   logic            e_mem_we;
   logic            e_branch;
   logic            e_jump;

   // Surrounding pipeline side: drives the instruction and context, observes decode.
   modport master (
      output ir, npc, flush, ex_mem_re, ex_rd, wb_we, wb_rd, wb_data,
      input  stallF, stallD, e_valid, e_pc, e_rs1_val, e_rs2_val, e_imm,
             e_rs1, e_rs2, e_rd, e_opcode, e_funct3, e_funct7b5,
             e_rd_we, e_mem_re, e_mem_we, e_branch, e_jump
   );

   // Decode stage side.
   modport slave (
      input  ir, npc, flush, ex_mem_re, ex_rd, wb_we, wb_rd, wb_data,
      output stallF, stallD, e_valid, e_pc, e_rs1_val, e_rs2_val, e_imm,
             e_rs1, e_rs2, e_rd, e_opcode, e_funct3, e_funct7b5,
             e_rd_we, e_mem_re, e_mem_we, e_branch, e_jump
   );

endinterface

// File: rtl/decode_stage_regfile.sv
// Integer register file: two asynchronous read ports, one synchronous write
// port with write-through to the readers, x0 hardwired to zero.
module decode_stage_regfile #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [$clog2(NREG)-1:0] ra1,
   output logic [XLEN-1:0]         rd1,
   input  logic [$clog2(NREG)-1:0] ra2,
   output logic [XLEN-1:0]         rd2,
   input  logic                    we,
   input  logic [$clog2(NREG)-1:0] wa,
   input  logic [XLEN-1:0]         wd
);

   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];

   // Next register contents: apply the write unless it targets x0.
   always_comb begin
      regs_d = regs_q;
      if (we && (wa != {AW{1'b0}})) begin
         regs_d[wa] = wd;
      end else begin
         regs_d = regs_q;
      end
   end

   // Register storage with synchronous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= {XLEN{1'b0}};
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read port 1: x0 reads zero, a same-cycle write is forwarded.
   always_comb begin
      rd1 = {XLEN{1'b0}};
      if (ra1 == {AW{1'b0}}) begin
         rd1 = {XLEN{1'b0}};
      end else if (we && (wa == ra1)) begin
         rd1 = wd;
      end else begin
         rd1 = regs_q[ra1];
      end
   end

   // Read port 2: same behaviour as port 1.
   always_comb begin
      rd2 = {XLEN{1'b0}};
      if (ra2 == {AW{1'b0}}) begin
         rd2 = {XLEN{1'b0}};
      end else if (we && (wa == ra2)) begin
         rd2 = wd;
      end else begin
         rd2 = regs_q[ra2];
      end
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate/control decode, register read,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic          clk,
   input  logic          reset,
   decode_stage_if.slave dif
);

   logic [6:0]        opcode_s;
   logic [REG_AW-1:0] rs1_s;
   logic [REG_AW-1:0] rs2_s;
   logic [REG_AW-1:0] rd_s;
   logic [XLEN-1:0]   rs1_val_s;
   logic [XLEN-1:0]   rs2_val_s;
   logic              rs1_used_s;
   logic              rs2_used_s;
   logic              hazard_s;
   logic              stall_s;
   logic              issue_s;
   idex_t             dec_s;
   idex_t             idex_d;
   idex_t             idex_q;
   logic              primed_d;
   logic              primed_q;

   assign opcode_s = dif.ir[6:0];
   assign rd_s     = dif.ir[11:7];
   assign rs1_s    = dif.ir[19:15];
   assign rs2_s    = dif.ir[24:20];

   decode_stage_regfile #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_regfile (
      .clk   (clk),
      .reset (reset),
      .ra1   (rs1_s),
      .rd1   (rs1_val_s),
      .ra2   (rs2_s),
      .rd2   (rs2_val_s),
      .we    (dif.wb_we),
      .wa    (dif.wb_rd),
      .wd    (dif.wb_data)
   );

   // Decode the instruction in ir into a full ID/EX entry plus operand-use flags.
   always_comb begin
      dec_s          = IDEX_ZERO;
      rs1_used_s     = 1'b0;
      rs2_used_s     = 1'b0;
      dec_s.valid    = 1'b1;
      dec_s.pc       = dif.npc;
      dec_s.rs1_val  = rs1_val_s;
      dec_s.rs2_val  = rs2_val_s;
      dec_s.imm      = imm_gen(dif.ir);
      dec_s.rs1      = rs1_s;
      dec_s.rs2      = rs2_s;
      dec_s.rd       = rd_s;
      dec_s.opcode   = opcode_s;
      dec_s.funct3   = dif.ir[14:12];
      dec_s.funct7b5 = dif.ir[30];
      case (opcode_s)
         OPC_OP: begin
            dec_s.rd_we = 1'b1;
            rs1_used_s  = 1'b1;
            rs2_used_s  = 1'b1;
         end
         OPC_OP_IMM: begin
            dec_s.rd_we = 1'b1;
            rs1_used_s  = 1'b1;
         end
         OPC_LOAD: begin
            dec_s.rd_we  = 1'b1;
            dec_s.mem_re = 1'b1;
            rs1_used_s   = 1'b1;
         end
         OPC_STORE: begin
            dec_s.mem_we = 1'b1;
            rs1_used_s   = 1'b1;
            rs2_used_s   = 1'b1;
         end
         OPC_BRANCH: begin
            dec_s.branch = 1'b1;
            rs1_used_s   = 1'b1;
            rs2_used_s   = 1'b1;
         end
         OPC_JAL: begin
            dec_s.rd_we = 1'b1;
            dec_s.jump  = 1'b1;
         end
         OPC_JALR: begin
            dec_s.rd_we = 1'b1;
            dec_s.jump  = 1'b1;
            rs1_used_s  = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: begin
            dec_s.rd_we = 1'b1;
         end
         default: begin
            // Unknown opcode: valid no-op; rs1 still counts as read.
            rs1_used_s = 1'b1;
         end
      endcase
      if (rd_s == 5'd0) begin
         dec_s.rd_we = 1'b0;
      end else begin
         dec_s.rd_we = dec_s.rd_we;
      end
   end

   // Load-use hazard and stall generation; flush and an unprimed pipe suppress the stall.
   always_comb begin
      hazard_s = primed_q && !reset && dif.ex_mem_re && (dif.ex_rd != 5'd0) &&
                 ((rs1_used_s && (rs1_s == dif.ex_rd)) ||
                  (rs2_used_s && (rs2_s == dif.ex_rd)));
      stall_s  = hazard_s && !dif.flush;
      issue_s  = primed_q && !dif.flush && !hazard_s;
   end

   assign dif.stallF = stall_s;
   assign dif.stallD = stall_s;

   // Next ID/EX entry: the decoded instruction, or a bubble with valid and controls cleared.
   always_comb begin
      idex_d   = dec_s;
      primed_d = 1'b1;
      if (issue_s) begin
         idex_d = dec_s;
      end else begin
         idex_d.valid  = 1'b0;
         idex_d.rd_we  = 1'b0;
         idex_d.mem_re = 1'b0;
         idex_d.mem_we = 1'b0;
         idex_d.branch = 1'b0;
         idex_d.jump   = 1'b0;
      end
   end

   // ID/EX pipeline register and startup flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         idex_q   <= IDEX_ZERO;
         primed_q <= 1'b0;
      end else begin
         idex_q   <= idex_d;
         primed_q <= primed_d;
      end
   end

   assign dif.e_valid    = idex_q.valid;
   assign dif.e_pc       = idex_q.pc;
   assign dif.e_rs1_val  = idex_q.rs1_val;
   assign dif.e_rs2_val  = idex_q.rs2_val;
   assign dif.e_imm      = idex_q.imm;
   assign dif.e_rs1      = idex_q.rs1;
   assign dif.e_rs2      = idex_q.rs2;
   assign dif.e_rd       = idex_q.rd;
   assign dif.e_opcode   = idex_q.opcode;
   assign dif.e_funct3   = idex_q.funct3;
   assign dif.e_funct7b5 = idex_q.funct7b5;
   assign dif.e_rd_we    = idex_q.rd_we;
   assign dif.e_mem_re   = idex_q.mem_re;
   assign dif.e_mem_we   = idex_q.mem_we;
   assign dif.e_branch   = idex_q.branch;
   assign dif.e_jump     = idex_q.jump;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   decode_stage_if #(.XLEN(32)) dif ();

   decode_stage #(.XLEN(32), .NREG(32)) dut (
      .clk   (clk),
      .reset (reset),
      .dif   (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      reset         = 1'b1;
      dif.ir        = 32'h0000_0000;
      dif.npc       = 32'h0000_0000;
      dif.flush     = 1'b0;
      dif.ex_mem_re = 1'b0;
      dif.ex_rd     = 5'd0;
      dif.wb_we     = 1'b0;
      dif.wb_rd     = 5'd0;
      dif.wb_data   = 32'h0000_0000;

      // Reset state
      tick();
      tick();
      chk("rst_valid", 32'(dif.e_valid), 32'd0);
      chk("rst_pc", dif.e_pc, 32'h0000_0000);
      chk("rst_stallF", 32'(dif.stallF), 32'd0);

      // Startup bubble, then addi x1,x0,5
      reset   = 1'b0;
      dif.ir  = 32'h0050_0093;
      dif.npc = 32'h0000_8000;
      #1;
      chk("prime_stallF", 32'(dif.stallF), 32'd0);
      tick();
      chk("prime_bubble", 32'(dif.e_valid), 32'd0);
      tick();
      chk("addi_valid", 32'(dif.e_valid), 32'd1);
      chk("addi_imm", dif.e_imm, 32'd5);
      chk("addi_rd", 32'(dif.e_rd), 32'd1);
      chk("addi_rd_we", 32'(dif.e_rd_we), 32'd1);
      chk("addi_pc", dif.e_pc, 32'h0000_8000);
      chk("addi_opcode", 32'(dif.e_opcode), 32'h13);

      // Write-through: add x4,x3,x3 while x3 is being written
      dif.wb_we   = 1'b1;
      dif.wb_rd   = 5'd3;
      dif.wb_data = 32'hDEAD_BEEF;
      dif.ir      = 32'h0031_8233;
      dif.npc     = 32'h0000_8004;
      tick();
      chk("wt_rs1", dif.e_rs1_val, 32'hDEAD_BEEF);
      chk("wt_rs2", dif.e_rs2_val, 32'hDEAD_BEEF);

      // Stored value read back
      dif.wb_we = 1'b0;
      dif.npc   = 32'h0000_8008;
      tick();
      chk("stored_rs1", dif.e_rs1_val, 32'hDEAD_BEEF);

      // Load-use hazard on rs1: add x5,x2,x1 with load to x2 in EX; write x2 meanwhile
      dif.ex_mem_re = 1'b1;
      dif.ex_rd     = 5'd2;
      dif.ir        = 32'h0011_02B3;
      dif.npc       = 32'h0000_800C;
      dif.wb_we     = 1'b1;
      dif.wb_rd     = 5'd2;
      dif.wb_data   = 32'h0BAD_F00D;
      #1;
      chk("haz_stallF", 32'(dif.stallF), 32'd1);
      chk("haz_stallD", 32'(dif.stallD), 32'd1);
      tick();
      chk("haz_bubble", 32'(dif.e_valid), 32'd0);
      chk("haz_rd_we", 32'(dif.e_rd_we), 32'd0);

      // Load has left EX: instruction issues, write during stall committed
      dif.ex_mem_re = 1'b0;
      dif.wb_we     = 1'b0;
      #1;
      chk("post_stallF", 32'(dif.stallF), 32'd0);
      tick();
      chk("post_valid", 32'(dif.e_valid), 32'd1);
      chk("post_rd", 32'(dif.e_rd), 32'd5);
      chk("post_pc", dif.e_pc, 32'h0000_800C);
      chk("post_rs1", dif.e_rs1_val, 32'h0BAD_F00D);
      chk("post_rs2", dif.e_rs2_val, 32'h0000_0000);

      // Hazard through rs2, and no hazard when the load targets x0
      dif.ex_mem_re = 1'b1;
      dif.ex_rd     = 5'd1;
      #1;
      chk("haz_rs2_stallD", 32'(dif.stallD), 32'd1);
      dif.ex_rd = 5'd0;
      #1;
      chk("haz_x0_stallD", 32'(dif.stallD), 32'd0);

      // Flush together with hazard: no stall, one bubble
      dif.ex_rd = 5'd2;
      dif.flush = 1'b1;
      #1;
      chk("flush_stallF", 32'(dif.stallF), 32'd0);
      chk("flush_stallD", 32'(dif.stallD), 32'd0);
      tick();
      chk("flush_bubble", 32'(dif.e_valid), 32'd0);
      chk("flush_rd_we", 32'(dif.e_rd_we), 32'd0);
      dif.flush     = 1'b0;
      dif.ex_mem_re = 1'b0;

      // beq x0,x0,-8
      dif.ir  = 32'hFE00_0CE3;
      dif.npc = 32'h0000_8010;
      tick();
      chk("beq_valid", 32'(dif.e_valid), 32'd1);
      chk("beq_imm", dif.e_imm, 32'hFFFF_FFF8);
      chk("beq_branch", 32'(dif.e_branch), 32'd1);
      chk("beq_rd_we", 32'(dif.e_rd_we), 32'd0);

      // lui x7,0x12345
      dif.ir = 32'h1234_53B7;
      tick();
      chk("lui_imm", dif.e_imm, 32'h1234_5000);
      chk("lui_rd_we", 32'(dif.e_rd_we), 32'd1);
      chk("lui_jump", 32'(dif.e_jump), 32'd0);

      // lw x8,-4(x2)
      dif.ir = 32'hFFC1_2403;
      tick();
      chk("lw_imm", dif.e_imm, 32'hFFFF_FFFC);
      chk("lw_mem_re", 32'(dif.e_mem_re), 32'd1);
      chk("lw_funct3", 32'(dif.e_funct3), 32'd2);

      // sw x3,8(x2)
      dif.ir = 32'h0031_2423;
      tick();
      chk("sw_imm", dif.e_imm, 32'd8);
      chk("sw_mem_we", 32'(dif.e_mem_we), 32'd1);
      chk("sw_rd_we", 32'(dif.e_rd_we), 32'd0);
      chk("sw_rs2", dif.e_rs2_val, 32'hDEAD_BEEF);

      // Unknown opcode: valid no-op
      dif.ir = 32'hFFFF_FFFF;
      tick();
      chk("unk_valid", 32'(dif.e_valid), 32'd1);
      chk("unk_imm", dif.e_imm, 32'd0);
      chk("unk_rd_we", 32'(dif.e_rd_we), 32'd0);
      chk("unk_jump", 32'(dif.e_jump), 32'd0);

      // Write x0 = 0x1234, read x0 in the same and the next cycle
      dif.wb_we   = 1'b1;
      dif.wb_rd   = 5'd0;
      dif.wb_data = 32'h0000_1234;
      dif.ir      = 32'h0000_0333;
      tick();
      chk("x0_wt", dif.e_rs1_val, 32'd0);
      dif.wb_we = 1'b0;
      tick();
      chk("x0_read", dif.e_rs2_val, 32'd0);
      chk("x6_rd_we", 32'(dif.e_rd_we), 32'd1);

      // addi x0,x0,5 never writes back
      dif.ir = 32'h0050_0013;
      tick();
      chk("rd0_rd_we", 32'(dif.e_rd_we), 32'd0);

      // Reset applied mid-stall
      dif.ex_mem_re = 1'b1;
      dif.ex_rd     = 5'd2;
      dif.ir        = 32'h0011_02B3;
      #1;
      chk("pre_rst_stall", 32'(dif.stallF), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_hi_stallF", 32'(dif.stallF), 32'd0);
      chk("rst_hi_stallD", 32'(dif.stallD), 32'd0);
      tick();
      chk("mid_rst_valid", 32'(dif.e_valid), 32'd0);
      chk("mid_rst_pc", dif.e_pc, 32'd0);
      chk("mid_rst_imm", dif.e_imm, 32'd0);
      chk("mid_rst_rs1val", dif.e_rs1_val, 32'd0);
      chk("mid_rst_rd", 32'(dif.e_rd), 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_stall", 32'(dif.stallF), 32'd0);
      tick();
      chk("post_rst_bubble", 32'(dif.e_valid), 32'd0);

      // Register file cleared by reset
      dif.ex_mem_re = 1'b0;
      dif.ir        = 32'h0031_8233;
      tick();
      chk("clr_valid", 32'(dif.e_valid), 32'd1);
      chk("clr_x3", dif.e_rs1_val, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
